dac_spi_tx: RTL and testbench



---
 rtl/dac_pkg.sv | 27 ++
 rtl/dac_sclk_gen.sv | 38 +++
 rtl/dac_spi_tx.sv | 136 +++++++++++++
 tb/tb_dac_spi_tx.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared types and helpers for the DAC SPI transmitter.
// Holds the frame state encoding, frame geometry and the frame builder.
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH
    } state_t;

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned CMD_W   = 4;
    localparam int unsigned PAY_W   = FRAME_W - CMD_W;

    // Sample arrives right-justified; it is left-justified under the command nibble.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [CMD_W-1:0] cmd,
        input logic [PAY_W-1:0] sample,
        input int unsigned      sample_w
    );
        logic [PAY_W-1:0] payload;
        payload = sample << (PAY_W - sample_w);
        return {cmd, payload};
    endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// SPI clock generator: divides clk by 2*CLK_DIV while enabled and flags
// the cycle on which SCLK is about to rise or fall.
module dac_sclk_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = en && (cnt == CW'(CLK_DIV - 1));
    assign rise = wrap && !sclk;
    assign fall = wrap && sclk;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (en) begin
            if (wrap) begin
                cnt  <= '0;
                sclk <= !sclk;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// Pops filtered samples at a fixed rate and shifts each one out as a
// 16-bit SPI frame to a serial DAC, followed by an LDAC strobe.
module dac_spi_tx
    import dac_pkg::*;
#(
    parameter int unsigned BUS_WIDTH     = 8,
    parameter int unsigned CLK_DIV       = 2,
    parameter int unsigned SAMPLE_PERIOD = 80,
    parameter logic [3:0]  CMD           = 4'b0011
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_enable,
    input  logic                 i_empty,
    input  logic [BUS_WIDTH-1:0] i_rd_data,
    output logic                 o_rd_inc,
    output logic                 o_sclk,
    output logic                 o_cs_n,
    output logic                 o_sdata,
    output logic                 o_ldac_n,
    output logic                 o_busy,
    output logic [BUS_WIDTH-1:0] o_last_sample,
    output logic [7:0]           o_underrun_cnt,
    output logic                 o_late
);

    localparam int unsigned TW = $clog2(SAMPLE_PERIOD);
    localparam int unsigned BW = $clog2(FRAME_W);

    state_t               state;
    logic [TW-1:0]        timer;
    logic [BW-1:0]        bit_cnt;
    logic [FRAME_W-1:0]   shift_reg;
    logic                 tick;
    logic                 sclk_en;
    logic                 sclk_rise;
    logic                 sclk_fall;

    assign tick    = i_enable && (timer == '0);
    assign sclk_en = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (!rst || !i_enable) begin
            timer <= '0;
        end else if (timer == TW'(SAMPLE_PERIOD - 1)) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    dac_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk (clk),
        .rst (rst),
        .en  (sclk_en),
        .clr (!sclk_en),
        .sclk(o_sclk),
        .rise(sclk_rise),
        .fall(sclk_fall)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            o_rd_inc       <= 1'b0;
            o_cs_n         <= 1'b1;
            o_sdata        <= 1'b0;
            o_ldac_n       <= 1'b1;
            o_busy         <= 1'b0;
            o_last_sample  <= '0;
            o_underrun_cnt <= '0;
            o_late         <= 1'b0;
        end else begin
            o_rd_inc <= 1'b0;
            o_ldac_n <= 1'b1;
            if (tick && state != IDLE) begin
                o_late <= 1'b1;
            end
            case (state)
                // The pop decision is taken on the tick so o_rd_inc is high
                // for exactly the LOAD cycle, while the FWFT head is still valid.
                IDLE: begin
                    if (tick) begin
                        state  <= LOAD;
                        o_busy <= 1'b1;
                        if (!i_empty) begin
                            o_rd_inc      <= 1'b1;
                            shift_reg     <= build_frame(CMD, PAY_W'(i_rd_data), BUS_WIDTH);
                            o_last_sample <= i_rd_data;
                        end else begin
                            shift_reg <= build_frame(CMD, PAY_W'(o_last_sample), BUS_WIDTH);
                            if (o_underrun_cnt != 8'hFF) begin
                                o_underrun_cnt <= o_underrun_cnt + 1'b1;
                            end
                        end
                    end
                end
                LOAD: begin
                    state   <= SHIFT;
                    o_cs_n  <= 1'b0;
                    o_sdata <= shift_reg[FRAME_W-1];
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        o_sdata <= shift_reg[FRAME_W-1];
                    end
                    if (sclk_fall) begin
                        shift_reg <= shift_reg << 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                        o_sdata   <= shift_reg[FRAME_W-2];
                        if (bit_cnt == BW'(FRAME_W - 1)) begin
                            state    <= LATCH;
                            bit_cnt  <= '0;
                            o_cs_n   <= 1'b1;
                            o_sdata  <= 1'b0;
                            o_ldac_n <= 1'b0;
                        end
                    end
                end
                LATCH: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench for dac_spi_tx: a queue-based FIFO/sample model predicts
// every SPI frame; monitors decode the serial lines and compare.
module tb_dac_spi_tx;

    localparam int unsigned BW  = 8;
    localparam int unsigned CD  = 2;
    localparam int unsigned SP  = 80;
    localparam int unsigned SP2 = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          empty = 1'b1;
    logic [BW-1:0] rd_data = '0;
    logic          rd_inc, sclk, cs_n, sdata, ldac_n, busy, late;
    logic [BW-1:0] last_sample;
    logic [7:0]    urun;

    logic          en2 = 1'b0;
    logic          empty2 = 1'b1;
    logic [BW-1:0] rd_data2 = '0;
    logic          rd_inc2, sclk2, cs_n2, sdata2, ldac_n2, busy2, late2;
    logic [BW-1:0] last_sample2;
    logic [7:0]    urun2;

    dac_spi_tx #(.BUS_WIDTH(BW), .CLK_DIV(CD), .SAMPLE_PERIOD(SP), .CMD(4'b0011)) dut (
        .clk(clk), .rst(rst), .i_enable(en), .i_empty(empty), .i_rd_data(rd_data),
        .o_rd_inc(rd_inc), .o_sclk(sclk), .o_cs_n(cs_n), .o_sdata(sdata),
        .o_ldac_n(ldac_n), .o_busy(busy), .o_last_sample(last_sample),
        .o_underrun_cnt(urun), .o_late(late));

    dac_spi_tx #(.BUS_WIDTH(BW), .CLK_DIV(CD), .SAMPLE_PERIOD(SP2), .CMD(4'b0011)) dut2 (
        .clk(clk), .rst(rst), .i_enable(en2), .i_empty(empty2), .i_rd_data(rd_data2),
        .o_rd_inc(rd_inc2), .o_sclk(sclk2), .o_cs_n(cs_n2), .o_sdata(sdata2),
        .o_ldac_n(ldac_n2), .o_busy(busy2), .o_last_sample(last_sample2),
        .o_underrun_cnt(urun2), .o_late(late2));

    typedef struct {
        logic [15:0] frame;
        int unsigned urun;
    } exp_t;

    exp_t          sb_q[$];
    logic [BW-1:0] fifo_q[$];
    logic [BW-1:0] model_q[$];
    int unsigned   m_last = 0;
    int unsigned   m_urun = 0;
    int            checks = 0;
    int            errors = 0;
    int unsigned   pops = 0;
    int unsigned   frames = 0;
    int unsigned   frames2 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each accepted tick takes the next queued sample, or repeats
    // the previous one and bumps a saturating underrun count.
    task automatic model_tick();
        exp_t e;
        if (model_q.size() > 0) begin
            m_last = model_q.pop_front();
        end else begin
            m_urun = (m_urun < 255) ? m_urun + 1 : 255;
        end
        e.frame = 16'(32'h3000 + m_last * 16);
        e.urun  = m_urun;
        sb_q.push_back(e);
    endtask

    task automatic load(input logic [BW-1:0] s);
        fifo_q.push_back(s);
        model_q.push_back(s);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            if (sb_q.size() == 0 && !busy) break;
            @(negedge clk);
        end
        check("drain_timeout", 32'(sb_q.size() == 0 && !busy), 32'd1);
    endtask

    task automatic run_frames(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) model_tick();
        @(negedge clk);
        @(negedge clk);
        en = 1'b1;
        repeat ((n - 1) * SP + 70) @(negedge clk);
        en = 1'b0;
        wait_drain();
    endtask

    // FIFO model: first-word-fall-through head, popped on o_rd_inc.
    always @(negedge clk) begin
        if (rst && rd_inc) begin
            pops++;
            check("pop_nonempty", 32'(fifo_q.size() > 0), 32'd1);
            check("pop_in_load", 32'(busy && cs_n && ldac_n), 32'd1);
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        empty   = (fifo_q.size() == 0);
        rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    bit          in_frame = 0;
    bit          prev_sclk = 0;
    int unsigned nbits = 0;
    int unsigned flen = 0;
    logic [15:0] fdata = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            in_frame  = 0;
            prev_sclk = 0;
        end else begin
            if (!cs_n) begin
                if (!in_frame) begin
                    in_frame = 1;
                    nbits = 0;
                    flen = 0;
                    fdata = '0;
                end
                flen++;
                if (sclk && !prev_sclk) begin
                    fdata = {fdata[14:0], sdata};
                    nbits++;
                end
            end else if (in_frame) begin
                in_frame = 0;
                frames++;
                check("ldac_at_cs_rise", 32'(ldac_n), 32'd0);
                check("cs_low_len", flen, 32'(32 * CD));
                check("bit_count", nbits, 32'd16);
                if (sb_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("frame_data", 32'(fdata), 32'(e.frame));
                    check("underrun_cnt", 32'(urun), e.urun);
                end
            end else begin
                check("ldac_idle", 32'(ldac_n), 32'd1);
                check("sclk_idle", 32'(sclk), 32'd0);
            end
            prev_sclk = sclk;
        end
    end

    bit          in2 = 0;
    bit          prev2 = 0;
    int unsigned nbits2 = 0;
    int unsigned flen2 = 0;
    logic [15:0] fdata2 = '0;

    always @(negedge clk) begin
        if (!rst) begin
            in2   = 0;
            prev2 = 0;
        end else begin
            if (!cs_n2) begin
                if (!in2) begin
                    in2 = 1;
                    nbits2 = 0;
                    flen2 = 0;
                    fdata2 = '0;
                end
                flen2++;
                if (sclk2 && !prev2) begin
                    fdata2 = {fdata2[14:0], sdata2};
                    nbits2++;
                end
            end else if (in2) begin
                in2 = 0;
                frames2++;
                check("short_bits", nbits2, 32'd16);
                check("short_len", flen2, 32'(32 * CD));
                check("short_data", 32'(fdata2), 32'h3000);
                check("short_ldac", 32'(ldac_n2), 32'd0);
            end
            prev2 = sclk2;
        end
    end

    initial begin
        int unsigned p0, f0, k, n, expp;
        logic [BW-1:0] s;

        repeat (3) @(negedge clk);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sdata", 32'(sdata), 32'd0);
        check("rst_ldac_n", 32'(ldac_n), 32'd1);
        check("rst_rd_inc", 32'(rd_inc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_last", 32'(last_sample), 32'd0);
        check("rst_urun", 32'(urun), 32'd0);
        check("rst_late", 32'(late), 32'd0);
        rst = 1'b1;

        // single 0xA5 frame with pop timing
        load(8'hA5);
        model_tick();
        @(negedge clk);
        @(negedge clk);
        p0 = pops;
        en = 1'b1;
        @(negedge clk);
        check("pop_cycle1", 32'(rd_inc), 32'd1);
        check("busy_load", 32'(busy), 32'd1);
        @(negedge clk);
        check("pop_cycle2", 32'(rd_inc), 32'd0);
        repeat (66) @(negedge clk);
        en = 1'b0;
        wait_drain();
        check("a5_pops", pops - p0, 32'd1);
        check("a5_last", 32'(last_sample), 32'hA5);

        // three samples then an underrun
        p0 = pops;
        load(8'h10);
        load(8'h20);
        load(8'h30);
        run_frames(4);
        check("seq_pops", pops - p0, 32'd3);
        check("seq_urun", 32'(urun), 32'd1);

        // randomized batches
        for (int it = 0; it < 5; it++) begin
            k = $urandom_range(0, 3);
            for (int unsigned j = 0; j < k; j++) begin
                s = 8'($urandom);
                load(s);
            end
            n = $urandom_range(1, 4);
            expp = (model_q.size() < n) ? model_q.size() : n;
            p0 = pops;
            run_frames(n);
            check("rand_pops", pops - p0, expp);
        end

        // enable dropped 10 cycles into a frame
        fifo_q.delete();
        model_q.delete();
        s = 8'($urandom);
        load(s);
        model_tick();
        @(negedge clk);
        @(negedge clk);
        p0 = pops;
        f0 = frames;
        en = 1'b1;
        repeat (10) @(negedge clk);
        en = 1'b0;
        repeat (200) @(negedge clk);
        check("drop_pops", pops - p0, 32'd1);
        check("drop_frames", frames - f0, 32'd1);
        check("drop_sb_empty", 32'(sb_q.size()), 32'd0);
        check("drop_timer", 32'(dut.timer), 32'd0);
        check("drop_busy", 32'(busy), 32'd0);

        // long empty run: underrun count saturates
        p0 = pops;
        run_frames(300);
        check("sat_urun", 32'(urun), 32'd255);
        check("sat_pops", pops - p0, 32'd0);

        // reset in the middle of SHIFT
        s = 8'($urandom);
        load(s);
        model_tick();
        @(negedge clk);
        @(negedge clk);
        p0 = pops;
        en = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_shift_cs", 32'(cs_n), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_cs_n", 32'(cs_n), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_ldac", 32'(ldac_n), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_urun", 32'(urun), 32'd0);
        check("abort_last", 32'(last_sample), 32'd0);
        check("abort_timer", 32'(dut.timer), 32'd0);
        check("abort_bitcnt", 32'(dut.bit_cnt), 32'd0);
        check("abort_pops", pops - p0, 32'd1);
        sb_q.delete();
        m_urun = 0;
        m_last = 0;
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        check("abort_no_pop", pops - p0, 32'd1);

        // period too short for a frame
        en2 = 1'b1;
        @(posedge clk);
        repeat (40) @(negedge clk);
        check("late_before_2nd", 32'(late2), 32'd0);
        @(negedge clk);
        check("late_after_2nd", 32'(late2), 32'd1);
        repeat (200) @(negedge clk);
        en2 = 1'b0;
        repeat (100) @(negedge clk);
        check("short_frames", 32'(frames2 >= 3), 32'd1);
        check("short_idle", 32'(busy2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
